// File: rtl/pipe_stage_reg.sv
// Pipeline stage register carrying LANES opaque data words plus a valid bit.
// It handles stall (hold), flush, and WFI sleep with a fixed priority.
// A flush that arrives while the stage is held is latched and applied when
// the hold releases. A saturating counter records the bubble cycles inserted.
module pipe_stage_reg #(
    parameter int unsigned      LANES     = 6,
    parameter int unsigned      WIDTH     = 32,
    parameter logic [WIDTH-1:0] NOP_VALUE = '0,
    parameter int unsigned      CNT_W     = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   hold,
    input  logic                   flush,
    input  logic                   wfi_req,
    input  logic                   wake,
    input  logic                   bubble_clr,
    input  logic                   in_valid,
    input  logic [LANES*WIDTH-1:0] in_data,
    output logic                   out_valid,
    output logic [LANES*WIDTH-1:0] out_data,
    output logic                   flush_pending,
    output logic                   sleeping,
    output logic [CNT_W-1:0]       bubble_cnt
);

    localparam logic [LANES*WIDTH-1:0] NOP_WORD = {LANES{NOP_VALUE}};

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_SLEEP = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [LANES*WIDTH-1:0] data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   pend_q, pend_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   bubble;

    // Next-state and datapath selection. Priority order: hold, then flush
    // (including a latched flush), then wfi, then a normal load.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        valid_d = valid_q;
        pend_d  = pend_q;
        bubble  = 1'b0;

        unique case (state_q)
            ST_RUN: begin
                if (hold) begin
                    // Freeze the stage; remember a flush so it is not lost.
                    if (flush) begin
                        pend_d = 1'b1;
                    end
                end else if (flush || pend_q) begin
                    data_d  = NOP_WORD;
                    valid_d = 1'b0;
                    pend_d  = 1'b0;
                    bubble  = 1'b1;
                end else if (wfi_req) begin
                    data_d  = NOP_WORD;
                    valid_d = 1'b0;
                    state_d = ST_SLEEP;
                    bubble  = 1'b1;
                end else begin
                    data_d  = in_data;
                    valid_d = in_valid;
                end
            end

            ST_SLEEP: begin
                if (hold) begin
                    if (flush) begin
                        pend_d = 1'b1;
                    end
                end else if (wake || flush || pend_q) begin
                    // Exit with one more bubble; loading resumes next cycle.
                    state_d = ST_RUN;
                    data_d  = NOP_WORD;
                    valid_d = 1'b0;
                    pend_d  = 1'b0;
                    bubble  = 1'b1;
                end else begin
                    data_d  = NOP_WORD;
                    valid_d = 1'b0;
                    bubble  = 1'b1;
                end
            end

            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Bubble counter: a clear beats an increment, and the count saturates
    // instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (bubble_clr) begin
            cnt_d = '0;
        end else if (bubble && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State registers. Reset also discards any latched flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            data_q  <= NOP_WORD;
            valid_q <= 1'b0;
            pend_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
        end
    end

    // Every output comes straight from a register.
    always_comb begin
        out_valid     = valid_q;
        out_data      = data_q;
        flush_pending = pend_q;
        sleeping      = (state_q == ST_SLEEP);
        bubble_cnt    = cnt_q;
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed vector table, hand
// sequences for counter saturation and async reset, then randomized traffic
// against a reference model.
module tb_pipe_stage_reg;

    localparam int unsigned LANES  = 6;
    localparam int unsigned WIDTH  = 32;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned CNT_W2 = 2;
    localparam int unsigned DW     = LANES * WIDTH;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          hold = 1'b0, flush = 1'b0, wfi_req = 1'b0, wake = 1'b0;
    logic          bubble_clr = 1'b0, in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;

    logic              out_valid, flush_pending, sleeping;
    logic [DW-1:0]     out_data;
    logic [CNT_W-1:0]  bubble_cnt;
    logic              out_valid2, flush_pending2, sleeping2;
    logic [DW-1:0]     out_data2;
    logic [CNT_W2-1:0] bubble_cnt2;

    pipe_stage_reg #(.LANES(LANES), .WIDTH(WIDTH), .NOP_VALUE(32'h0), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .hold(hold), .flush(flush), .wfi_req(wfi_req),
        .wake(wake), .bubble_clr(bubble_clr), .in_valid(in_valid), .in_data(in_data),
        .out_valid(out_valid), .out_data(out_data), .flush_pending(flush_pending),
        .sleeping(sleeping), .bubble_cnt(bubble_cnt)
    );

    pipe_stage_reg #(.LANES(LANES), .WIDTH(WIDTH), .NOP_VALUE(32'h0), .CNT_W(CNT_W2)) dut_small (
        .clk(clk), .rst_n(rst_n), .hold(hold), .flush(flush), .wfi_req(wfi_req),
        .wake(wake), .bubble_clr(bubble_clr), .in_valid(in_valid), .in_data(in_data),
        .out_valid(out_valid2), .out_data(out_data2), .flush_pending(flush_pending2),
        .sleeping(sleeping2), .bubble_cnt(bubble_cnt2)
    );

    always #5 clk = ~clk;

    int unsigned total = 0;
    int unsigned bad   = 0;

    // Reference model state
    logic [WIDTH-1:0] m_lane[LANES];
    bit               m_valid, m_pend, m_sleep;
    int unsigned      m_cnt, m_cnt2;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] m_packed();
        logic [DW-1:0] v;
        v = '0;
        for (int k = 0; k < LANES; k++) v[k*WIDTH +: WIDTH] = m_lane[k];
        return v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < LANES; k++) m_lane[k] = '0;
        m_valid = 0; m_pend = 0; m_sleep = 0; m_cnt = 0; m_cnt2 = 0;
    endtask

    task automatic model_nop();
        for (int k = 0; k < LANES; k++) m_lane[k] = '0;
        m_valid = 0;
    endtask

    // Apply one clock edge of the stage rules to the model, using the
    // inputs currently driven.
    task automatic model_edge();
        bit bub;
        bub = 0;
        if (hold) begin
            if (flush) m_pend = 1;
        end else if (m_sleep) begin
            bub = 1;
            model_nop();
            if (wake || flush || m_pend) begin
                m_sleep = 0;
                m_pend  = 0;
            end
        end else if (flush || m_pend) begin
            bub = 1; model_nop(); m_pend = 0;
        end else if (wfi_req) begin
            bub = 1; model_nop(); m_sleep = 1;
        end else begin
            for (int k = 0; k < LANES; k++) m_lane[k] = in_data[k*WIDTH +: WIDTH];
            m_valid = in_valid;
        end
        if (bubble_clr) begin
            m_cnt = 0; m_cnt2 = 0;
        end else if (bub) begin
            if (m_cnt  < (2**CNT_W)  - 1) m_cnt++;
            if (m_cnt2 < (2**CNT_W2) - 1) m_cnt2++;
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, " data"},    out_data,            m_packed());
        chk({tag, " valid"},   DW'(out_valid),      DW'(m_valid));
        chk({tag, " pending"}, DW'(flush_pending),  DW'(m_pend));
        chk({tag, " sleep"},   DW'(sleeping),       DW'(m_sleep));
        chk({tag, " cnt"},     DW'(bubble_cnt),     DW'(m_cnt));
        chk({tag, " cnt2"},    DW'(bubble_cnt2),    DW'(m_cnt2));
    endtask

    task automatic step(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_model(tag);
    endtask

    task automatic set_in(input bit h, input bit f, input bit w, input bit wk,
                          input bit c, input bit iv, input logic [31:0] l0);
        hold = h; flush = f; wfi_req = w; wake = wk; bubble_clr = c; in_valid = iv;
        for (int k = 0; k < LANES; k++) in_data[k*WIDTH +: WIDTH] = l0 + 32'(k);
    endtask

    task automatic do_reset();
        set_in(0, 0, 0, 0, 0, 0, 32'h0);
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        #1;
    endtask

    typedef struct {
        bit          h, f, w, wk, c, iv;
        logic [31:0] l0;
        bit          ev;
        logic [31:0] el0;
        bit          ep, es;
        int unsigned ec;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit h, bit f, bit w, bit wk, bit c, bit iv, logic [31:0] l0,
                                bit ev, logic [31:0] el0, bit ep, bit es, int unsigned ec);
        vec_t v;
        v.h = h; v.f = f; v.w = w; v.wk = wk; v.c = c; v.iv = iv; v.l0 = l0;
        v.ev = ev; v.el0 = el0; v.ep = ep; v.es = es; v.ec = ec;
        return v;
    endfunction

    initial begin
        //             h f w wk c iv lane0        ev el0        ep es cnt
        tbl.push_back(mk(0,0,0,0,0,1,32'h100,  1,32'h100, 0,0,0));  // normal load
        tbl.push_back(mk(1,1,0,0,0,1,32'h111,  1,32'h100, 1,0,0));  // flush under hold
        tbl.push_back(mk(1,0,0,0,0,1,32'h122,  1,32'h100, 1,0,0));
        tbl.push_back(mk(1,0,1,0,0,1,32'h133,  1,32'h100, 1,0,0));  // wfi ignored in hold
        tbl.push_back(mk(0,0,0,0,0,1,32'h200,  0,32'h0,   0,0,1));  // latched flush applied
        tbl.push_back(mk(0,0,0,0,0,1,32'h200,  1,32'h200, 0,0,1));
        tbl.push_back(mk(0,0,1,0,0,1,32'h300,  0,32'h0,   0,1,2));  // enter sleep
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(0,0,0,0,0,1,32'h400, 0,32'h0, 0,1,3+i)); // sleeping, data ignored
        tbl.push_back(mk(0,0,0,1,0,1,32'h450,  0,32'h0,   0,0,8));  // wake
        tbl.push_back(mk(0,0,0,0,0,1,32'h500,  1,32'h500, 0,0,8));
        tbl.push_back(mk(0,1,1,0,0,1,32'h550,  0,32'h0,   0,0,9));  // flush beats wfi
        tbl.push_back(mk(0,0,0,0,0,1,32'h600,  1,32'h600, 0,0,9));
        tbl.push_back(mk(1,0,1,0,0,1,32'h700,  1,32'h600, 0,0,9));  // hold beats wfi
        tbl.push_back(mk(0,0,0,0,0,0,32'h800,  0,32'h800, 0,0,9));  // invalid load, no bubble
        tbl.push_back(mk(0,0,1,1,0,1,32'h900,  0,32'h0,   0,1,10)); // wake+wfi in RUN -> sleep
        tbl.push_back(mk(1,1,0,0,0,1,32'h910,  0,32'h0,   1,1,10)); // flush latched in sleep
        tbl.push_back(mk(0,0,0,0,0,1,32'h920,  0,32'h0,   0,0,11)); // pending flush wakes
        tbl.push_back(mk(0,0,0,0,0,1,32'h930,  1,32'h930, 0,0,11));
        tbl.push_back(mk(0,1,0,0,1,1,32'h940,  0,32'h0,   0,0,0));  // clear beats increment
        tbl.push_back(mk(0,0,0,0,0,1,32'h950,  1,32'h950, 0,0,0));
        tbl.push_back(mk(0,0,1,0,0,1,32'h960,  0,32'h0,   0,1,1));
        tbl.push_back(mk(0,1,0,0,0,1,32'h970,  0,32'h0,   0,0,2));  // flush wakes
        tbl.push_back(mk(0,0,0,0,0,1,32'h980,  1,32'h980, 0,0,2));

        // Reset state
        model_reset();
        #1 rst_n = 1'b0;
        #1;
        chk("reset data",  out_data,            '0);
        chk("reset valid", DW'(out_valid),      '0);
        chk("reset pend",  DW'(flush_pending),  '0);
        chk("reset sleep", DW'(sleeping),       '0);
        chk("reset cnt",   DW'(bubble_cnt),     '0);
        do_reset();

        // Directed table
        foreach (tbl[i]) begin
            set_in(tbl[i].h, tbl[i].f, tbl[i].w, tbl[i].wk, tbl[i].c, tbl[i].iv, tbl[i].l0);
            step($sformatf("vec%0d", i));
            chk($sformatf("vec%0d tbl valid", i), DW'(out_valid),     DW'(tbl[i].ev));
            chk($sformatf("vec%0d tbl lane0", i), DW'(out_data[31:0]), DW'(tbl[i].el0));
            chk($sformatf("vec%0d tbl pend", i),  DW'(flush_pending), DW'(tbl[i].ep));
            chk($sformatf("vec%0d tbl sleep", i), DW'(sleeping),      DW'(tbl[i].es));
            chk($sformatf("vec%0d tbl cnt", i),   DW'(bubble_cnt),    DW'(tbl[i].ec));
        end

        // Counter saturation on the 2-bit instance
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_in(0, 1, 0, 0, 0, 1, 32'hA0);
            step($sformatf("sat%0d", i));
            chk($sformatf("sat%0d cnt2", i), DW'(bubble_cnt2), DW'((i < 3) ? i + 1 : 3));
            chk($sformatf("sat%0d cnt", i),  DW'(bubble_cnt),  DW'(i + 1));
        end
        set_in(0, 1, 0, 0, 1, 1, 32'hA0);
        step("satclr");
        chk("satclr cnt2", DW'(bubble_cnt2), '0);
        chk("satclr cnt",  DW'(bubble_cnt),  '0);

        // Async reset while sleeping with a latched flush
        set_in(0, 0, 1, 0, 0, 1, 32'hB0);
        step("ar wfi");
        set_in(1, 1, 0, 0, 0, 1, 32'hB1);
        step("ar hold");
        chk("ar pre pend",  DW'(flush_pending), DW'(1));
        chk("ar pre sleep", DW'(sleeping),      DW'(1));
        #3 rst_n = 1'b0;
        model_reset();
        #1;
        chk("ar data",  out_data,            '0);
        chk("ar valid", DW'(out_valid),      '0);
        chk("ar pend",  DW'(flush_pending),  '0);
        chk("ar sleep", DW'(sleeping),       '0);
        chk("ar cnt",   DW'(bubble_cnt),     '0);
        #1 rst_n = 1'b1;
        set_in(0, 0, 0, 0, 0, 1, 32'hABC);
        step("ar resume");
        chk("ar resume lane0", DW'(out_data[31:0]), DW'(32'hABC));
        chk("ar resume valid", DW'(out_valid),      DW'(1));
        chk("ar resume cnt",   DW'(bubble_cnt),     '0);

        // Randomized traffic against the model
        for (int n = 0; n < 800; n++) begin
            hold       = ($urandom_range(0, 3) == 0);
            flush      = ($urandom_range(0, 6) == 0);
            wfi_req    = ($urandom_range(0, 9) == 0);
            wake       = ($urandom_range(0, 4) == 0);
            bubble_clr = ($urandom_range(0, 40) == 0);
            in_valid   = $urandom_range(0, 1) != 0;
            for (int k = 0; k < LANES; k++) in_data[k*WIDTH +: WIDTH] = $urandom;
            step($sformatf("rnd%0d", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
